bcd_scan_display: RTL and testbench



---
 rtl/bcd_scan_display.sv | 151 +++++++++++++++
 tb/tb_bcd_scan_display.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Time-multiplexed three-digit seven-segment scanner with frame-aligned value adoption.
// Optional leading-zero blanking of tens/hundreds is enabled by defining SEVSEG_LZB_EN.
module bcd_scan_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [1:0] hundreds,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       frame_done,
    output logic       load_pending
);

    localparam int MAX_SLOT = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W    = $clog2(MAX_SLOT + 1);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_DASH = 7'b1000000;

    typedef enum logic {
        S_GAP,
        S_ON
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [9:0]       r_pending;
    logic [9:0]       r_shadow;
    logic [9:0]       w_shadow_nxt;
    logic             r_load_pending;
    logic             w_boundary;
    logic [3:0]       w_digit;
    logic             w_blank;
    logic [2:0]       r_an;
    logic [2:0]       w_an_nxt;
    logic [6:0]       r_seg;
    logic [6:0]       w_seg_nxt;
    logic             r_frame_done;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b0111111;
            4'd1:    f_decode = 7'b0000110;
            4'd2:    f_decode = 7'b1011011;
            4'd3:    f_decode = 7'b1001111;
            4'd4:    f_decode = 7'b1100110;
            4'd5:    f_decode = 7'b1101101;
            4'd6:    f_decode = 7'b1111101;
            4'd7:    f_decode = 7'b0000111;
            4'd8:    f_decode = 7'b1111111;
            4'd9:    f_decode = 7'b1101111;
            default: f_decode = SEG_DASH;
        endcase
    endfunction

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_boundary  = 1'b0;
        case (r_state)
            S_GAP: if (r_cnt == GAP_LAST) begin
                w_state_nxt = S_ON;
                w_cnt_nxt   = '0;
                w_boundary  = (r_idx == 2'd0);
            end
            S_ON: if (r_cnt == ON_LAST) begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = '0;
                w_idx_nxt   = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end
            default: w_state_nxt = S_GAP;
        endcase

        // The decode on the boundary edge must already see the adopted value.
        w_shadow_nxt = (w_boundary && r_load_pending) ? r_pending : r_shadow;

        case (w_idx_nxt)
            2'd0:    w_digit = w_shadow_nxt[3:0];
            2'd1:    w_digit = w_shadow_nxt[7:4];
            default: w_digit = (w_shadow_nxt[9:8] == 2'd3) ? 4'hF : {2'b00, w_shadow_nxt[9:8]};
        endcase

`ifdef SEVSEG_LZB_EN
        w_blank = ((w_idx_nxt == 2'd2) && (w_shadow_nxt[9:8] == 2'd0)) ||
                  ((w_idx_nxt == 2'd1) && (w_shadow_nxt[9:8] == 2'd0) && (w_shadow_nxt[7:4] == 4'd0));
`else
        w_blank = 1'b0;
`endif

        w_an_nxt  = 3'b111;
        w_seg_nxt = 7'b0000000;
        if (w_state_nxt == S_ON && !w_blank) begin
            w_an_nxt  = ~(3'b001 << w_idx_nxt);
            w_seg_nxt = f_decode(w_digit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending      <= '0;
            r_shadow       <= '0;
            r_load_pending <= 1'b0;
            r_an           <= 3'b111;
            r_seg          <= 7'b0000000;
            r_frame_done   <= 1'b0;
        end else begin
            r_shadow     <= w_shadow_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_boundary;
            // A load on the boundary edge stays pending for the following frame.
            if (load) begin
                r_pending      <= {hundreds, tens, ones};
                r_load_pending <= 1'b1;
            end else if (w_boundary) begin
                r_load_pending <= 1'b0;
            end
        end
    end

    assign an           = r_an;
    assign seg          = r_seg;
    assign frame_done   = r_frame_done;
    assign load_pending = r_load_pending;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display (REFRESH_DIV=4, GAP_CYCLES=1, 15-cycle frame).
// Per-cycle expectations are queued as stimulus is planned and popped after each edge.
module tb_bcd_scan_display;

    localparam int REFRESH_DIV = 4;
    localparam int GAP_CYCLES  = 1;
    localparam int FRAME       = 3 * (REFRESH_DIV + GAP_CYCLES);

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [1:0] hundreds;
    logic [2:0] an;
    logic [6:0] seg;
    logic       frame_done;
    logic       load_pending;

    typedef struct {
        logic [2:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       lp;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   frame_no = 0;

    bcd_scan_display #(
        .REFRESH_DIV(REFRESH_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .ones        (ones),
        .tens        (tens),
        .hundreds    (hundreds),
        .an          (an),
        .seg         (seg),
        .frame_done  (frame_done),
        .load_pending(load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic push(input logic [2:0] a, input logic [6:0] s, input logic f, input logic l, input string tag);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.fd  = f;
        e.lp  = l;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // One full frame starting at the frame_done cycle; load_pending is 1 from cycle lp_on onward.
    task automatic push_frame(input logic [3:0] o, input logic [3:0] t, input logic [1:0] h, input int lp_on);
        logic [6:0] s_h;
        logic       blank_t;
        logic       blank_h;
        s_h = (h == 2'd3) ? 7'b1000000 : seg_of({2'b00, h});
`ifdef SEVSEG_LZB_EN
        blank_h = (h == 2'd0);
        blank_t = (h == 2'd0) && (t == 4'd0);
`else
        blank_h = 1'b0;
        blank_t = 1'b0;
`endif
        for (int k = 0; k < FRAME; k++) begin
            string tg;
            logic  l;
            tg = $sformatf("f%0d_c%0d", frame_no, k);
            l  = (k >= lp_on);
            if (k < 4)
                push(3'b110, seg_of(o), k == 0, l, tg);
            else if (k >= 5 && k < 9)
                push(blank_t ? 3'b111 : 3'b101, blank_t ? 7'b0 : seg_of(t), 1'b0, l, tg);
            else if (k >= 10 && k < 14)
                push(blank_h ? 3'b111 : 3'b011, blank_h ? 7'b0 : s_h, 1'b0, l, tg);
            else
                push(3'b111, 7'b0, 1'b0, l, tg);
        end
        frame_no++;
    endtask

    task automatic check_next();
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL queue_empty: observed=0 required=entry");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (an === e.an) else begin
                failures++;
                $error("FAIL %s an: observed=%b required=%b", e.tag, an, e.an);
            end
            checks++;
            assert (seg === e.seg) else begin
                failures++;
                $error("FAIL %s seg: observed=%b required=%b", e.tag, seg, e.seg);
            end
            checks++;
            assert (frame_done === e.fd) else begin
                failures++;
                $error("FAIL %s frame_done: observed=%b required=%b", e.tag, frame_done, e.fd);
            end
            checks++;
            assert (load_pending === e.lp) else begin
                failures++;
                $error("FAIL %s load_pending: observed=%b required=%b", e.tag, load_pending, e.lp);
            end
        end
    endtask

    task automatic tick(input logic ld, input logic [1:0] h, input logic [3:0] t, input logic [3:0] o);
        load     = ld;
        hundreds = h;
        tens     = t;
        ones     = o;
        @(posedge clk);
        #1;
        load = 1'b0;
        check_next();
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        ones     = 4'd0;
        tens     = 4'd0;
        hundreds = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        push(3'b111, 7'b0, 1'b0, 1'b0, "reset");
        check_next();
        rst = 1'b0;
        push(3'b111, 7'b0, 1'b0, 1'b0, "cycle0_gap");
        check_next();

        // Frame 0: zeros after reset; 255 loaded at cycle 7, not shown this frame.
        push_frame(4'd0, 4'd0, 2'd0, 7);
        for (int k = 0; k < FRAME; k++) tick(k == 7, 2'd2, 4'd5, 4'd5);

        // Frame 1: shows 255; two loads, the later one (007) must win.
        push_frame(4'd5, 4'd5, 2'd2, 3);
        for (int k = 0; k < FRAME; k++) begin
            if (k == 3)       tick(1'b1, 2'd1, 4'd2, 4'd3);
            else if (k == 10) tick(1'b1, 2'd0, 4'd0, 4'd7);
            else              tick(1'b0, 2'd0, 4'd0, 4'd0);
        end

        // Frame 2: shows 007 with nothing pending.
        push_frame(4'd7, 4'd0, 2'd0, FRAME);
        for (int k = 0; k < FRAME; k++) tick(1'b0, 2'd0, 4'd0, 4'd0);

        // Frame 3: invalid value loaded on the boundary edge; frame keeps 007.
        push_frame(4'd7, 4'd0, 2'd0, 0);
        for (int k = 0; k < FRAME; k++) tick(k == 0, 2'd3, 4'd8, 4'hC);

        // Frame 4: dash / 8 / dash; load 199 at cycle 5.
        push_frame(4'hC, 4'd8, 2'd3, 5);
        for (int k = 0; k < FRAME; k++) tick(k == 5, 2'd1, 4'd9, 4'd9);

        // Frame 5: two cycles of ones=9, a fresh load, then asynchronous reset.
        push(3'b110, seg_of(4'd9), 1'b1, 1'b0, "f5_c0");
        tick(1'b0, 2'd0, 4'd0, 4'd0);
        push(3'b110, seg_of(4'd9), 1'b0, 1'b1, "f5_c1");
        tick(1'b1, 2'd0, 4'd0, 4'd1);
        #2;
        rst = 1'b1;
        #1;
        push(3'b111, 7'b0, 1'b0, 1'b0, "async_reset");
        check_next();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(3'b111, 7'b0, 1'b0, 1'b0, "post_reset_gap");
        check_next();

        // Shadow and pending contents were lost: a zero frame with nothing pending.
        frame_no = 6;
        push_frame(4'd0, 4'd0, 2'd0, FRAME);
        for (int k = 0; k < FRAME; k++) tick(1'b0, 2'd0, 4'd0, 4'd0);

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL queue_drain: observed=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
